// File: rtl/isa_pkg.sv
// ECE350 ISA constants, field layout and the loader FSM state type.
package isa_pkg;

    localparam int unsigned OP_WIDTH = 5;

    localparam logic [4:0] OP_R    = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;

    // LSB position of each field within the 32-bit word
    localparam int unsigned OP_LSB    = 27;
    localparam int unsigned RD_LSB    = 22;
    localparam int unsigned RS_LSB    = 17;
    localparam int unsigned RT_LSB    = 12;
    localparam int unsigned SHAMT_LSB = 7;
    localparam int unsigned ALUOP_LSB = 2;

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_JI, FMT_JII, FMT_ILL} fmt_e;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    function automatic fmt_e op_format(input logic [4:0] op);
        fmt_e fmt;
        case (op)
            OP_R:                                 fmt = FMT_R;
            OP_ADDI, OP_SW, OP_LW, OP_BNE, OP_BLT: fmt = FMT_I;
            OP_J, OP_JAL, OP_SETX, OP_BEX:        fmt = FMT_JI;
            OP_JR:                                fmt = FMT_JII;
            default:                              fmt = FMT_ILL;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Request handshake plus imem write bus of the instruction loader.
interface instr_encoder_loader_if #(
    parameter int unsigned ADDR_WIDTH = 12
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic                  in_last;
    logic [4:0]            in_op;
    logic [4:0]            in_rd;
    logic [4:0]            in_rs;
    logic [4:0]            in_rt;
    logic [4:0]            in_shamt;
    logic [4:0]            in_aluop;
    logic [16:0]           in_imm;
    logic [26:0]           in_target;
    logic                  imem_wren;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_data;

    // Request source and imem sink side
    modport master (
        output in_valid, in_last, in_op, in_rd, in_rs, in_rt, in_shamt, in_aluop,
               in_imm, in_target,
        input  in_ready, imem_wren, imem_addr, imem_data
    );

    // Loader side
    modport slave (
        input  in_valid, in_last, in_op, in_rd, in_rs, in_rt, in_shamt, in_aluop,
               in_imm, in_target,
        output in_ready, imem_wren, imem_addr, imem_data
    );
endinterface

// File: rtl/instr_field_packer.sv
// Combinational opcode/field to 32-bit instruction word packer.
module instr_field_packer
    import isa_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  shamt,
    input  logic [4:0]  aluop,
    input  logic [16:0] imm,
    input  logic [26:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Select the format and place each field; unsupported opcodes become a nop
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op_format(op))
            FMT_R: word = (32'(op) << OP_LSB) | (32'(rd) << RD_LSB) | (32'(rs) << RS_LSB)
                        | (32'(rt) << RT_LSB) | (32'(shamt) << SHAMT_LSB)
                        | (32'(aluop) << ALUOP_LSB);
            FMT_I:   word = (32'(op) << OP_LSB) | (32'(rd) << RD_LSB) | (32'(rs) << RS_LSB)
                          | 32'(imm);
            FMT_JI:  word = (32'(op) << OP_LSB) | 32'(target);
            FMT_JII: word = (32'(op) << OP_LSB) | (32'(rd) << RD_LSB);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes instruction requests and streams them into imem at consecutive addresses.
module instr_encoder_loader
    import isa_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    instr_encoder_loader_if.slave  bus,
    output logic [ADDR_WIDTH:0]    count,
    output logic                   busy,
    output logic                   done,
    output logic                   err_illegal,
    output logic                   err_overflow
);

    localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;
    localparam logic [ADDR_WIDTH:0]   CountMax = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
    logic                  wren_q, wren_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  err_ill_q, err_ill_d;
    logic                  err_ovf_q, err_ovf_d;

    logic        xfer;
    logic        start_ok;
    logic        at_last;
    logic [31:0] enc_word;
    logic        enc_illegal;

    assign xfer     = bus.in_valid && (state_q == StRun);
    assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));
    assign at_last  = (addr_cnt_q == LastAddr);

    instr_field_packer u_packer (
        .op      (bus.in_op),
        .rd      (bus.in_rd),
        .rs      (bus.in_rs),
        .rt      (bus.in_rt),
        .shamt   (bus.in_shamt),
        .aluop   (bus.in_aluop),
        .imm     (bus.in_imm),
        .target  (bus.in_target),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // FSM next state; the last address forces a drain so the counter never wraps
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone: if (start) state_d = StRun;
            StRun:          if (xfer && (bus.in_last || at_last)) state_d = StDrain;
            StDrain:        state_d = StDone;
            default:        state_d = StIdle;
        endcase
    end

    // Pipeline register, address/count counters and sticky flags
    always_comb begin
        wren_d     = xfer;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        addr_cnt_d = addr_cnt_q;
        count_d    = count_q;
        err_ill_d  = err_ill_q;
        err_ovf_d  = err_ovf_q;
        if (start_ok) begin
            addr_cnt_d = BaseAddr;
            count_d    = '0;
            err_ill_d  = 1'b0;
            err_ovf_d  = 1'b0;
        end else if (xfer) begin
            waddr_d = addr_cnt_q;
            wdata_d = enc_word;
            if (!at_last) addr_cnt_d = addr_cnt_q + 1'b1;
            if (count_q != CountMax) count_d = count_q + 1'b1;
            if (enc_illegal) err_ill_d = 1'b1;
            if (at_last && !bus.in_last) err_ovf_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StIdle;
            addr_cnt_q <= BaseAddr;
            wren_q     <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            count_q    <= '0;
            err_ill_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            wren_q     <= wren_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
            err_ill_q  <= err_ill_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

    assign bus.in_ready  = (state_q == StRun);
    assign bus.imem_wren = wren_q;
    assign bus.imem_addr = waddr_q;
    assign bus.imem_data = wdata_q;
    assign count         = count_q;
    assign busy          = (state_q == StRun) || (state_q == StDrain);
    assign done          = (state_q == StDone);
    assign err_illegal   = err_ill_q;
    assign err_overflow  = err_ovf_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: a 12-bit/base-16 loader and a 2-bit/base-0 loader share one request stream.
module tb_instr_encoder_loader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_b = 1'b0;
    logic start_s = 1'b0;

    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [4:0]  in_op = '0, in_rd = '0, in_rs = '0, in_rt = '0, in_shamt = '0, in_aluop = '0;
    logic [16:0] in_imm = '0;
    logic [26:0] in_target = '0;

    logic [12:0] count_b;
    logic        busy_b, done_b, ill_b, ovf_b;
    logic [2:0]  count_s;
    logic        busy_s, done_s, ill_s, ovf_s;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    instr_encoder_loader_if #(.ADDR_WIDTH(12)) bus_b ();
    instr_encoder_loader_if #(.ADDR_WIDTH(2))  bus_s ();

    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_last   = in_last;
    assign bus_b.in_op     = in_op;
    assign bus_b.in_rd     = in_rd;
    assign bus_b.in_rs     = in_rs;
    assign bus_b.in_rt     = in_rt;
    assign bus_b.in_shamt  = in_shamt;
    assign bus_b.in_aluop  = in_aluop;
    assign bus_b.in_imm    = in_imm;
    assign bus_b.in_target = in_target;
    assign bus_s.in_valid  = in_valid;
    assign bus_s.in_last   = in_last;
    assign bus_s.in_op     = in_op;
    assign bus_s.in_rd     = in_rd;
    assign bus_s.in_rs     = in_rs;
    assign bus_s.in_rt     = in_rt;
    assign bus_s.in_shamt  = in_shamt;
    assign bus_s.in_aluop  = in_aluop;
    assign bus_s.in_imm    = in_imm;
    assign bus_s.in_target = in_target;

    instr_encoder_loader #(.ADDR_WIDTH(12), .BASE_ADDR(16)) dut_b (
        .clock        (clk),
        .reset        (rst_n),
        .start        (start_b),
        .bus          (bus_b.slave),
        .count        (count_b),
        .busy         (busy_b),
        .done         (done_b),
        .err_illegal  (ill_b),
        .err_overflow (ovf_b)
    );

    instr_encoder_loader #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut_s (
        .clock        (clk),
        .reset        (rst_n),
        .start        (start_s),
        .bus          (bus_s.slave),
        .count        (count_s),
        .busy         (busy_s),
        .done         (done_s),
        .err_illegal  (ill_s),
        .err_overflow (ovf_s)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic req(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [16:0] imm, input logic [26:0] tgt,
                       input logic last);
        in_valid  = 1'b1;
        in_op     = op;
        in_rd     = rd;
        in_rs     = rs;
        in_rt     = rt;
        in_shamt  = '0;
        in_aluop  = '0;
        in_imm    = imm;
        in_target = tgt;
        in_last   = last;
    endtask

    task automatic chk_reset_b(input string tag);
        chk({tag, "_b_ready"}, 32'(bus_b.in_ready), 32'd0);
        chk({tag, "_b_wren"},  32'(bus_b.imem_wren), 32'd0);
        chk({tag, "_b_addr"},  32'(bus_b.imem_addr), 32'd0);
        chk({tag, "_b_data"},  bus_b.imem_data, 32'd0);
        chk({tag, "_b_count"}, 32'(count_b), 32'd0);
        chk({tag, "_b_stat"},  32'({busy_b, done_b, ill_b, ovf_b}), 32'd0);
    endtask

    task automatic chk_reset_s(input string tag);
        chk({tag, "_s_ready"}, 32'(bus_s.in_ready), 32'd0);
        chk({tag, "_s_wren"},  32'(bus_s.imem_wren), 32'd0);
        chk({tag, "_s_addr"},  32'(bus_s.imem_addr), 32'd0);
        chk({tag, "_s_data"},  bus_s.imem_data, 32'd0);
        chk({tag, "_s_count"}, 32'(count_s), 32'd0);
        chk({tag, "_s_stat"},  32'({busy_s, done_s, ill_s, ovf_s}), 32'd0);
    endtask

    initial begin
        logic [6:0] pat;
        int k;

        // Reset
        tick();
        tick();
        chk_reset_b("rst");
        chk_reset_s("rst");
        rst_n = 1'b1;

        // Single R-type on the base-0 loader
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        chk("r_run_busy", 32'(busy_s), 32'd1);
        chk("r_run_ready", 32'(bus_s.in_ready), 32'd1);
        req(5'b00000, 5'd3, 5'd1, 5'd2, 17'd0, 27'd0, 1'b1);
        tick();
        chk("r_wren", 32'(bus_s.imem_wren), 32'd1);
        chk("r_addr", 32'(bus_s.imem_addr), 32'd0);
        chk("r_data", bus_s.imem_data, 32'h00C22000);
        chk("r_drain_ready", 32'(bus_s.in_ready), 32'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        chk("r_done", 32'(done_s), 32'd1);
        chk("r_count", 32'(count_s), 32'd1);
        chk("r_wren_off", 32'(bus_s.imem_wren), 32'd0);
        chk("r_data_hold", bus_s.imem_data, 32'h00C22000);

        // Back-to-back on base-16 loader; start with in_valid in IDLE must not transfer
        req(5'b00101, 5'd1, 5'd0, 5'd0, 17'd5, 27'd0, 1'b0);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b2b_start_nowr", 32'(bus_b.imem_wren), 32'd0);
        chk("b2b_start_cnt", 32'(count_b), 32'd0);
        tick();
        chk("b2b_addi_addr", 32'(bus_b.imem_addr), 32'd16);
        chk("b2b_addi_data", bus_b.imem_data, 32'h28400005);
        req(5'b01000, 5'd2, 5'd1, 5'd0, 17'd0, 27'd0, 1'b0);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("b2b_lw_wren", 32'(bus_b.imem_wren), 32'd1);
        chk("b2b_lw_addr", 32'(bus_b.imem_addr), 32'd17);
        chk("b2b_lw_data", bus_b.imem_data, 32'h40820000);
        req(5'b00001, 5'd0, 5'd0, 5'd0, 17'd0, 27'h100, 1'b1);
        tick();
        chk("b2b_j_addr", 32'(bus_b.imem_addr), 32'd18);
        chk("b2b_j_data", bus_b.imem_data, 32'h08000100);
        chk("b2b_j_busy", 32'(busy_b), 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        chk("b2b_done", 32'(done_b), 32'd1);
        chk("b2b_count", 32'(count_b), 32'd3);

        // Gapped jr stream, restarted from DONE
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        chk("gap_restart_cnt", 32'(count_b), 32'd0);
        chk("gap_restart_done", 32'(done_b), 32'd0);
        pat = 7'b1001101;
        k = 0;
        req(5'b00100, 5'd31, 5'd0, 5'd0, 17'd0, 27'd0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            in_valid = pat[i];
            in_last  = (i == 6);
            tick();
            chk($sformatf("gap_wren%0d", i), 32'(bus_b.imem_wren), 32'(pat[i]));
            if (pat[i]) begin
                chk($sformatf("gap_addr%0d", i), 32'(bus_b.imem_addr), 32'(16 + k));
                chk($sformatf("gap_data%0d", i), bus_b.imem_data, 32'h27C00000);
                k++;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        chk("gap_done", 32'(done_b), 32'd1);
        chk("gap_count", 32'(count_b), 32'd4);

        // Illegal opcode mid-stream
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        req(5'b00101, 5'd1, 5'd0, 5'd0, 17'd5, 27'd0, 1'b0);
        tick();
        chk("ill_addi_data", bus_b.imem_data, 32'h28400005);
        chk("ill_flag_pre", 32'(ill_b), 32'd0);
        req(5'b01001, 5'd7, 5'd3, 5'd0, 17'h1234, 27'h1234, 1'b0);
        tick();
        chk("ill_wren", 32'(bus_b.imem_wren), 32'd1);
        chk("ill_addr", 32'(bus_b.imem_addr), 32'd17);
        chk("ill_data", bus_b.imem_data, 32'h0);
        chk("ill_flag", 32'(ill_b), 32'd1);
        req(5'b00100, 5'd31, 5'd0, 5'd0, 17'd0, 27'd0, 1'b1);
        tick();
        chk("ill_jr_addr", 32'(bus_b.imem_addr), 32'd18);
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        chk("ill_done", 32'(done_b), 32'd1);
        chk("ill_sticky", 32'(ill_b), 32'd1);
        chk("ill_no_ovf", 32'(ovf_b), 32'd0);
        chk("ill_count", 32'(count_b), 32'd3);

        // Overflow on the 4-word loader: five requests, no in_last
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        req(5'b00101, 5'd1, 5'd0, 5'd0, 17'd5, 27'd0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("ovf_wren%0d", i), 32'(bus_s.imem_wren), 32'd1);
            chk($sformatf("ovf_addr%0d", i), 32'(bus_s.imem_addr), 32'(i));
        end
        chk("ovf_ready_low", 32'(bus_s.in_ready), 32'd0);
        chk("ovf_flag", 32'(ovf_s), 32'd1);
        tick();
        chk("ovf_fifth_dropped", 32'(bus_s.imem_wren), 32'd0);
        chk("ovf_addr_hold", 32'(bus_s.imem_addr), 32'd3);
        chk("ovf_done", 32'(done_s), 32'd1);
        chk("ovf_count", 32'(count_s), 32'd4);
        chk("ovf_sticky", 32'(ovf_s), 32'd1);
        in_valid = 1'b0;

        // Reset during RUN with a transfer pending
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        req(5'b00101, 5'd1, 5'd0, 5'd0, 17'd5, 27'd0, 1'b0);
        tick();
        chk("mrst_pre_wren", 32'(bus_b.imem_wren), 32'd1);
        rst_n = 1'b0;
        tick();
        chk_reset_b("mrst");
        chk_reset_s("mrst");
        rst_n    = 1'b1;
        in_valid = 1'b0;
        start_b  = 1'b1;
        tick();
        start_b = 1'b0;
        req(5'b00100, 5'd31, 5'd0, 5'd0, 17'd0, 27'd0, 1'b1);
        tick();
        chk("mrst_re_addr", 32'(bus_b.imem_addr), 32'd16);
        chk("mrst_re_data", bus_b.imem_data, 32'h27C00000);
        in_valid = 1'b0;
        in_last  = 1'b0;
        tick();
        chk("mrst_re_done", 32'(done_b), 32'd1);
        chk("mrst_re_count", 32'(count_b), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
